// File: rtl/core_v1_pkg.sv
// Purpose: shared constants for the core_v1 fetch path (reset PC, NOP encoding, fetch FSM states).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_v1_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t S_IDLE = 2'd0;
  localparam fetch_state_t S_REQ  = 2'd1;
  localparam fetch_state_t S_WAIT = 2'd2;
  localparam fetch_state_t S_OUT  = 2'd3;

endpackage

// File: rtl/fetch_out_buf.sv
// Purpose: one-entry registered holding stage for {pc, instr} presented to decode.
// Latency: load to out_valid is 1 cycle; flush clears valid on the next edge.
// Backpressure: contents held stable while out_valid && !out_ready; flush beats load and handshake.
module fetch_out_buf
  import core_v1_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  // Valid flag: flush drops a held entry even if decode is accepting it this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Payload only changes on an accepted load, so it stays stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pc    <= 32'h0000_0000;
      out_instr <= NOP_INSTR;
    end else if (load && !flush) begin
      out_pc    <= load_pc;
      out_instr <= load_instr;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Purpose: owns the PC, issues one imem fetch at a time, squashes wrong-path responses after redirect.
// Latency: request accept to if_valid = imem latency + 1; 1 instr / 3 cycles with 1-cycle imem.
// Backpressure: imem request held until imem_req_ready; decode stall holds if_* and blocks new fetches.
module fetch_pc_unit
  import core_v1_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic         drop_q, drop_d;
  logic         req_fire;
  logic         buf_load;

  assign req_fire = imem_req_valid && imem_req_ready;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      drop_q        <= drop_d;
    end
  end

  // Next-state: normal fetch sequencing, then redirect overrides it from any state.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    drop_d        = drop_q;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (req_fire) begin
          state_d       = S_WAIT;
          inflight_pc_d = pc_q;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            pc_d    = inflight_pc_q + 32'd4;
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (if_valid && if_ready) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid) begin
      pc_d = redirect_pc & ~32'd3;
      unique case (state_q)
        S_IDLE, S_OUT: state_d = S_REQ;
        S_REQ: begin
          // An accepted request is already on the wrong path; mark its response for discard.
          if (req_fire) drop_d = 1'b1;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs: request driven from state/pc; buffer loads only a live, unsquashed response.
  always_comb begin
    imem_req_valid = (state_q == S_REQ);
    imem_req_addr  = pc_q;
    buf_load       = (state_q == S_WAIT) && imem_rsp_valid && !drop_q && !redirect_valid;
  end

  fetch_out_buf u_out_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (buf_load),
    .load_pc    (inflight_pc_q),
    .load_instr (imem_rsp_data),
    .flush      (redirect_valid),
    .out_ready  (if_ready),
    .out_valid  (if_valid),
    .out_pc     (if_pc),
    .out_instr  (if_instr)
  );

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int total;
  int passed;
  int failed;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starting in S_REQ with imem and decode both ready: one full 3-cycle fetch.
  task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
    chk({tag, " req_valid"}, {31'd0, imem_req_valid}, 32'd1);
    chk({tag, " req_addr"}, imem_req_addr, addr);
    tick();
    chk({tag, " req_drop"}, {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
    chk({tag, " if_valid"}, {31'd0, if_valid}, 32'd1);
    chk({tag, " if_pc"}, if_pc, addr);
    chk({tag, " if_instr"}, if_instr, data);
    tick();
    chk({tag, " if_valid_clr"}, {31'd0, if_valid}, 32'd0);
  endtask

  initial begin
    total = 0; passed = 0; failed = 0;
    rst_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    if_ready = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst req_addr", imem_req_addr, 32'h0000_0000);
    chk("rst if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst if_pc", if_pc, 32'h0000_0000);
    chk("rst if_instr", if_instr, 32'h0000_0013);

    // Release; IDLE -> REQ on first edge
    rst_n = 1'b1;
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    tick();
    do_fetch("seq0", 32'h0000_0000, 32'h1111_0013);
    do_fetch("seq4", 32'h0000_0004, 32'h2222_0013);
    do_fetch("seq8", 32'h0000_0008, 32'h3333_0013);

    // Decode stall: 5 cycles holding the entry, no new request
    chk("stall req_addr", imem_req_addr, 32'h0000_000C);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h4444_0013;
    if_ready = 1'b0;
    tick();
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall if_valid", {31'd0, if_valid}, 32'd1);
      chk("stall if_pc", if_pc, 32'h0000_000C);
      chk("stall if_instr", if_instr, 32'h4444_0013);
      chk("stall no_req", {31'd0, imem_req_valid}, 32'd0);
      tick();
    end
    if_ready = 1'b1;
    tick();
    chk("stall release if_valid", {31'd0, if_valid}, 32'd0);
    chk("stall next addr", imem_req_addr, 32'h0000_0010);

    // Redirect to 0x100 while waiting; late response must be dropped
    tick();                                  // request 0x10 accepted -> WAIT
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    chk("rdw still waiting", {31'd0, imem_req_valid}, 32'd0);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    chk("rdw if_valid", {31'd0, if_valid}, 32'd0);
    chk("rdw req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rdw req_addr", imem_req_addr, 32'h0000_0100);
    do_fetch("rdw fetch", 32'h0000_0100, 32'h5555_0013);

    // Redirect 0x203 in S_OUT with decode ready in the same cycle
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h6666_0013;
    tick();
    imem_rsp_valid = 1'b0;
    chk("rdo held", {31'd0, if_valid}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0;
    chk("rdo if_valid", {31'd0, if_valid}, 32'd0);
    chk("rdo req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rdo req_addr", imem_req_addr, 32'h0000_0200);

    // Redirect 0x40 coincident with the response
    tick();                                  // request 0x200 accepted -> WAIT
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0013;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    tick();
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    chk("rdc if_valid", {31'd0, if_valid}, 32'd0);
    chk("rdc req_addr", imem_req_addr, 32'h0000_0040);
    do_fetch("rdc fetch", 32'h0000_0040, 32'h7777_0013);

    // Redirect while request stalled, then PC wrap at top of address space
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    do_fetch("wrap", 32'hFFFF_FFFC, 32'h8888_0013);
    chk("wrap next addr", imem_req_addr, 32'h0000_0000);

    // Reset asserted mid-WAIT; response right after release ignored
    tick();                                  // request 0x0 accepted -> WAIT
    rst_n = 1'b0;
    #1;
    chk("mid rst req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("mid rst req_addr", imem_req_addr, 32'h0000_0000);
    chk("mid rst if_valid", {31'd0, if_valid}, 32'd0);
    chk("mid rst if_pc", if_pc, 32'h0000_0000);
    chk("mid rst if_instr", if_instr, 32'h0000_0013);
    tick();
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFE_0013;
    tick();
    imem_rsp_valid = 1'b0;
    chk("post rst if_valid", {31'd0, if_valid}, 32'd0);
    do_fetch("post rst fetch", 32'h0000_0000, 32'h9999_0013);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
